cohub_mp: RTL and testbench

Parametrised coherence hub for the SoC. It connects PN coherent agents (port 0 memory, then SDC, MMU, and additional cores or DMA). Each port's request is buffered and forwarded once to every other port. Per-port snoop responses are collected and merged, and the originator gets a single response with the strongest MESI state. A sticky round-robin bus lock arbitrates atomic sequences between ports.

---
 rtl/cohub_pkg.sv | 27 ++
 rtl/cohub_slot.sv | 122 ++++++++++++
 rtl/cohub_mp.sv | 117 +++++++++++
 tb/tb_cohub_mp.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cohub_pkg.sv
// Shared types for the cohub_mp coherence hub: MESI encoding, merge helper, slot control state.
package cohub_pkg;

  typedef enum logic [1:0] {
    MESI_I = 2'd0,
    MESI_S = 2'd1,
    MESI_E = 2'd2,
    MESI_M = 2'd3
  } mesi_e;

  localparam logic [7:0] MESI_ERR = 8'hFF;

  // Out-of-range snoop states saturate to M so a faulty agent can only strengthen the merge.
  function automatic mesi_e mesi_max(input mesi_e a, input logic [7:0] b);
    mesi_e bb;
    bb = (b > 8'd3) ? MESI_M : mesi_e'(b[1:0]);
    return (bb > a) ? bb : a;
  endfunction

  typedef struct packed {
    logic  busy;
    logic  done;
    logic  tmo;
    mesi_e mesi;
  } slot_ctl_t;

endpackage

// File: rtl/cohub_slot.sv
// One request slot per port: accept, sent/resp masks, MESI merge, completion.
// COHUB_TIMEOUT_EN adds a per-slot counter that forces an error completion after TMO cycles.
module cohub_slot
  import cohub_pkg::*;
#(
  parameter int PN   = 3,
  parameter int AW   = 64,
  parameter int IW   = 8,
  parameter int SELF = 0,
  parameter int TMO  = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IW-1:0]       rqst_i,
  input  logic [IW-1:0]       trsc_i,
  input  logic [AW-1:0]       addr_i,
  input  logic [PN-1:0]       fwd_i,
  input  logic [PN-1:0]       hit_i,
  input  logic [PN-1:0][7:0]  m_mesi_i,
  output logic                act_o,
  output logic [PN-1:0]       pend_o,
  output logic [IW-1:0]       id_o,
  output logic [IW-1:0]       trsc_o,
  output logic [AW-1:0]       addr_o,
  output logic [IW-1:0]       resp_o,
  output logic [7:0]          mesi_o
);

  slot_ctl_t      ctl_q, ctl_d;
  logic [IW-1:0]  id_q, id_d, trsc_q, trsc_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [PN-1:0]  sent_q, sent_d, resp_q, resp_d, self_m;
  logic           accept;
`ifdef COHUB_TIMEOUT_EN
  localparam int CW = $clog2(TMO + 1);
  logic [CW-1:0]  cnt_q, cnt_d;
`endif

  always_comb begin
    self_m       = '0;
    self_m[SELF] = 1'b1;
  end

  // The completion cycle frees the slot, so a request issued then is taken at the same edge.
  assign accept = (!ctl_q.busy || ctl_q.done) && (rqst_i != '0);

  always_comb begin
    ctl_d  = ctl_q;
    id_d   = id_q;
    trsc_d = trsc_q;
    addr_d = addr_q;
    sent_d = sent_q;
    resp_d = resp_q;
`ifdef COHUB_TIMEOUT_EN
    cnt_d  = cnt_q;
`endif
    if (accept) begin
      id_d     = rqst_i;
      trsc_d   = trsc_i;
      addr_d   = addr_i;
      sent_d   = self_m;
      resp_d   = self_m;
      ctl_d.busy = 1'b1;
      ctl_d.done = &self_m;
      ctl_d.tmo  = 1'b0;
      ctl_d.mesi = MESI_I;
`ifdef COHUB_TIMEOUT_EN
      cnt_d    = '0;
`endif
    end else if (ctl_q.done) begin
      ctl_d.busy = 1'b0;
      ctl_d.done = 1'b0;
      ctl_d.tmo  = 1'b0;
    end else if (ctl_q.busy) begin
      sent_d = sent_q | fwd_i;
      resp_d = resp_q | hit_i;
      for (int j = 0; j < PN; j++)
        if (hit_i[j]) ctl_d.mesi = mesi_max(ctl_d.mesi, m_mesi_i[j]);
      ctl_d.done = &resp_d;
`ifdef COHUB_TIMEOUT_EN
      cnt_d = cnt_q + 1'b1;
      if (!(&resp_d) && cnt_d == CW'(TMO)) begin
        ctl_d.done = 1'b1;
        ctl_d.tmo  = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_q  <= '0;
      id_q   <= '0;
      trsc_q <= '0;
      addr_q <= '0;
      sent_q <= '0;
      resp_q <= '0;
`ifdef COHUB_TIMEOUT_EN
      cnt_q  <= '0;
`endif
    end else begin
      ctl_q  <= ctl_d;
      id_q   <= id_d;
      trsc_q <= trsc_d;
      addr_q <= addr_d;
      sent_q <= sent_d;
      resp_q <= resp_d;
`ifdef COHUB_TIMEOUT_EN
      cnt_q  <= cnt_d;
`endif
    end
  end

  assign act_o  = ctl_q.busy && !ctl_q.done;
  assign pend_o = act_o ? ~sent_q : '0;
  assign id_o   = id_q;
  assign trsc_o = trsc_q;
  assign addr_o = addr_q;
  assign resp_o = ctl_q.done ? id_q : '0;
  assign mesi_o = !ctl_q.done ? 8'h00 : (ctl_q.tmo ? MESI_ERR : {6'b0, ctl_q.mesi});

endmodule

// File: rtl/cohub_mp.sv
// Coherence hub top: per-port slots, lowest-index-first snoop broadcast, response fan-in,
// and a sticky round-robin lock arbiter. COHUB_TIMEOUT_EN enables slot timeouts.
module cohub_mp
  import cohub_pkg::*;
#(
  parameter int PN  = 3,
  parameter int AW  = 64,
  parameter int IW  = 8,
  parameter int TMO = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [PN-1:0]           s_lock,
  input  logic [PN-1:0][IW-1:0]   s_rqst,
  input  logic [PN-1:0][IW-1:0]   s_trsc,
  input  logic [PN-1:0][AW-1:0]   s_addr,
  output logic [PN-1:0][IW-1:0]   s_resp,
  output logic [PN-1:0][7:0]      s_mesi,
  output logic [PN-1:0]           m_lock,
  output logic [PN-1:0][IW-1:0]   m_rqst,
  output logic [PN-1:0][IW-1:0]   m_trsc,
  output logic [PN-1:0][AW-1:0]   m_addr,
  input  logic [PN-1:0][IW-1:0]   m_resp,
  input  logic [PN-1:0][7:0]      m_mesi
);

  localparam int LW = (PN > 1) ? $clog2(PN) : 1;

  logic [PN-1:0]           act;
  logic [PN-1:0][IW-1:0]   sid, strc;
  logic [PN-1:0][AW-1:0]   sadr;
  logic [PN-1:0][PN-1:0]   pend, fwd, hit;
  logic [PN-1:0]           taken;

  for (genvar k = 0; k < PN; k++) begin : g_slot
    cohub_slot #(.PN(PN), .AW(AW), .IW(IW), .SELF(k), .TMO(TMO)) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .rqst_i   (s_rqst[k]),
      .trsc_i   (s_trsc[k]),
      .addr_i   (s_addr[k]),
      .fwd_i    (fwd[k]),
      .hit_i    (hit[k]),
      .m_mesi_i (m_mesi),
      .act_o    (act[k]),
      .pend_o   (pend[k]),
      .id_o     (sid[k]),
      .trsc_o   (strc[k]),
      .addr_o   (sadr[k]),
      .resp_o   (s_resp[k]),
      .mesi_o   (s_mesi[k])
    );
  end

  // Per target, the lowest pending slot wins; its sent bit flips at this edge so it shows once.
  always_comb begin
    fwd    = '0;
    m_rqst = '0;
    m_trsc = '0;
    m_addr = '0;
    taken  = '0;
    for (int j = 0; j < PN; j++)
      for (int k = 0; k < PN; k++)
        if (!taken[j] && pend[k][j]) begin
          taken[j]  = 1'b1;
          fwd[k][j] = 1'b1;
          m_rqst[j] = sid[k];
          m_trsc[j] = strc[k];
          m_addr[j] = sadr[k];
        end
  end

  always_comb begin
    hit = '0;
    for (int k = 0; k < PN; k++)
      for (int j = 0; j < PN; j++)
        if (j != k && act[k] && m_resp[j] != '0 && m_resp[j] == sid[k])
          hit[k][j] = 1'b1;
  end

  // last_q starts at PN-1 so an idle hub searches from port 0.
  logic [PN-1:0] gnt_q, gnt_d;
  logic [LW-1:0] last_q, last_d, idx;
  logic          found;

  always_comb begin
    gnt_d  = '0;
    last_d = last_q;
    found  = 1'b0;
    idx    = '0;
    if (|(gnt_q & s_lock)) begin
      gnt_d = gnt_q;
    end else begin
      for (int off = 1; off <= PN; off++) begin
        idx = LW'((int'(last_q) + off) % PN);
        if (!found && s_lock[idx]) begin
          found      = 1'b1;
          gnt_d[idx] = 1'b1;
          last_d     = idx;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q  <= '0;
      last_q <= LW'(PN - 1);
    end else begin
      gnt_q  <= gnt_d;
      last_q <= last_d;
    end
  end

  assign m_lock = gnt_q;

endmodule

// File: tb/tb_cohub_mp.sv
// Self-checking bench for cohub_mp: lock vector table, directed corner sequences,
// randomized traffic against a slot-level reference model.
module tb_cohub_mp;
  localparam int PN = 3, AW = 64, IW = 8, TMO = 16;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [PN-1:0]         s_lock = '0, m_lock;
  logic [PN-1:0][IW-1:0] s_rqst = '0, s_trsc = '0, s_resp, m_rqst, m_trsc, m_resp = '0;
  logic [PN-1:0][AW-1:0] s_addr = '0, m_addr;
  logic [PN-1:0][7:0]    s_mesi, m_mesi = '0;

  always #5 clk = ~clk;

  cohub_mp #(.PN(PN), .AW(AW), .IW(IW), .TMO(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .s_lock(s_lock), .s_rqst(s_rqst), .s_trsc(s_trsc),
    .s_addr(s_addr), .s_resp(s_resp), .s_mesi(s_mesi), .m_lock(m_lock),
    .m_rqst(m_rqst), .m_trsc(m_trsc), .m_addr(m_addr), .m_resp(m_resp), .m_mesi(m_mesi));

  int n_chk = 0, n_pass = 0, cyc = 0;
  bit auto_en = 0, spur_en = 0;

  // reference model: per slot
  bit            mb[PN], md[PN], mt[PN];
  logic [IW-1:0] mid[PN], mtr[PN];
  logic [AW-1:0] mad[PN];
  bit            ms[PN][PN], mr[PN][PN];
  int            mm[PN], mc[PN];
  int            holder, lastp;

  typedef struct { int port; logic [7:0] id; logic [7:0] mesi; int due; } pend_t;
  pend_t pq[$];

  typedef struct { logic [PN-1:0] lk; logic [PN-1:0] gnt; } lock_vec_t;
  lock_vec_t ltab[12];

  task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got %0h expected %0h (cycle %0d)", nm, idx, act, exp, cyc);
  endtask

  task automatic model_reset();
    for (int k = 0; k < PN; k++) begin
      mb[k] = 0; md[k] = 0; mt[k] = 0; mm[k] = 0; mc[k] = 0;
      mid[k] = '0; mtr[k] = '0; mad[k] = '0;
      for (int j = 0; j < PN; j++) begin ms[k][j] = 0; mr[k][j] = 0; end
    end
    holder = -1; lastp = PN - 1;
  endtask

  function automatic int src_of(int j);
    for (int k = 0; k < PN; k++)
      if (mb[k] && !md[k] && !ms[k][j]) return k;
    return -1;
  endfunction

  task automatic model_step();
    int src[PN];
    bit free[PN];
    bit all;
    int v;
    for (int j = 0; j < PN; j++) src[j] = src_of(j);
    for (int k = 0; k < PN; k++) free[k] = !mb[k] || md[k];
    for (int k = 0; k < PN; k++) begin
      if (mb[k] && md[k]) begin
        mb[k] = 0; md[k] = 0; mt[k] = 0;
      end else if (mb[k]) begin
        for (int j = 0; j < PN; j++) if (src[j] == k) ms[k][j] = 1;
        for (int j = 0; j < PN; j++)
          if (j != k && m_resp[j] != 0 && m_resp[j] == mid[k]) begin
            mr[k][j] = 1;
            v = (m_mesi[j] > 3) ? 3 : int'(m_mesi[j]);
            if (v > mm[k]) mm[k] = v;
          end
        all = 1;
        for (int j = 0; j < PN; j++) if (!mr[k][j]) all = 0;
        md[k] = all;
`ifdef COHUB_TIMEOUT_EN
        mc[k]++;
        if (!all && mc[k] == TMO) begin md[k] = 1; mt[k] = 1; end
`endif
      end
      if (free[k] && s_rqst[k] != 0) begin
        mb[k] = 1; mid[k] = s_rqst[k]; mtr[k] = s_trsc[k]; mad[k] = s_addr[k];
        for (int j = 0; j < PN; j++) begin ms[k][j] = (j == k); mr[k][j] = (j == k); end
        mm[k] = 0; mt[k] = 0; mc[k] = 0; md[k] = (PN == 1);
      end
    end
    if (!(holder >= 0 && s_lock[holder])) begin
      holder = -1;
      for (int off = 1; off <= PN; off++)
        if (holder < 0 && s_lock[(lastp + off) % PN]) begin
          holder = (lastp + off) % PN; lastp = holder;
        end
    end
  endtask

  task automatic check_outputs();
    logic [PN-1:0] eg;
    int s;
    for (int k = 0; k < PN; k++) begin
      chk("s_resp", k, s_resp[k], md[k] ? mid[k] : 8'h00);
      chk("s_mesi", k, s_mesi[k], md[k] ? (mt[k] ? 8'hFF : 8'(mm[k])) : 8'h00);
      s = src_of(k);
      chk("m_rqst", k, m_rqst[k], (s >= 0) ? mid[s] : 8'h00);
      chk("m_trsc", k, m_trsc[k], (s >= 0) ? mtr[s] : 8'h00);
      chk("m_addr", k, m_addr[k], (s >= 0) ? mad[s] : 64'h0);
    end
    eg = '0;
    if (holder >= 0) eg[holder] = 1'b1;
    chk("m_lock", 0, m_lock, eg);
  endtask

  task automatic responder();
    for (int j = 0; j < PN; j++) begin
      for (int i = 0; i < pq.size(); i++)
        if (pq[i].port == j && pq[i].due <= cyc) begin
          m_resp[j] = pq[i].id; m_mesi[j] = pq[i].mesi; pq.delete(i); break;
        end
      if (spur_en && m_resp[j] == 0 && $urandom_range(15) == 0) begin
        m_resp[j] = 8'hE0 | 8'($urandom_range(15)); m_mesi[j] = 8'($urandom);
      end
    end
  endtask

  // One clock: inputs already set; model follows the edge; outputs compared mid-cycle.
  task automatic cycle();
    int s;
    if (auto_en) responder();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    check_outputs();
    if (auto_en)
      for (int j = 0; j < PN; j++) begin
        s = src_of(j);
        if (s >= 0) pq.push_back('{j, mid[s], 8'($urandom_range(7)), cyc + $urandom_range(2)});
      end
    s_rqst = '0; m_resp = '0; m_mesi = '0;
  endtask

  int seq[PN];

  initial begin
    ltab[0]  = '{3'b101, 3'b001}; ltab[1]  = '{3'b101, 3'b001};
    ltab[2]  = '{3'b100, 3'b100}; ltab[3]  = '{3'b100, 3'b100};
    ltab[4]  = '{3'b101, 3'b100}; ltab[5]  = '{3'b001, 3'b001};
    ltab[6]  = '{3'b001, 3'b001}; ltab[7]  = '{3'b000, 3'b000};
    ltab[8]  = '{3'b010, 3'b010}; ltab[9]  = '{3'b011, 3'b010};
    ltab[10] = '{3'b100, 3'b100}; ltab[11] = '{3'b000, 3'b000};
    model_reset();

    #3;
    chk("rst_s_resp", 0, s_resp, 0); chk("rst_s_mesi", 0, s_mesi, 0);
    chk("rst_m_lock", 0, m_lock, 0); chk("rst_m_rqst", 0, m_rqst, 0);
    chk("rst_m_trsc", 0, m_trsc, 0); chk("rst_m_addr", 0, m_addr[0] | m_addr[1] | m_addr[2], 0);
    @(negedge clk); rst_n = 1'b1;

    // lock arbiter table
    for (int i = 0; i < 12; i++) begin
      s_lock = ltab[i].lk;
      cycle();
      chk("lock_tbl", i, m_lock, ltab[i].gnt);
    end
    s_lock = '0;

    // single request, combinational answers, merged M
    s_rqst[1] = 8'h11; s_trsc[1] = 8'h05; s_addr[1] = 64'hDEAD_BEEF_0000_1000;
    cycle();
    chk("t1_fwd0", 0, m_rqst[0], 8'h11); chk("t1_fwd2", 2, m_rqst[2], 8'h11);
    chk("t1_addr0", 0, m_addr[0], 64'hDEAD_BEEF_0000_1000);
    m_resp[0] = 8'h11; m_mesi[0] = 8'd1; m_resp[2] = 8'h11; m_mesi[2] = 8'd3;
    cycle();
    chk("t1_resp", 1, s_resp[1], 8'h11); chk("t1_mesi", 1, s_mesi[1], 8'd3);
    chk("t1_nofwd", 0, m_rqst, 0);
    cycle();
    chk("t1_once", 1, s_resp[1], 8'h00);

    // contention on slow target 0
    s_rqst[1] = 8'h11; s_rqst[2] = 8'h22;
    cycle();
    chk("t2_first", 0, m_rqst[0], 8'h11);
    m_resp[2] = 8'h11; m_mesi[2] = 8'd1; m_resp[1] = 8'h22; m_mesi[1] = 8'd2;
    cycle();
    chk("t2_second", 0, m_rqst[0], 8'h22);
    cycle();
    m_resp[0] = 8'h11; m_mesi[0] = 8'd0;
    cycle();
    chk("t2_resp1", 1, s_resp[1], 8'h11); chk("t2_mesi1", 1, s_mesi[1], 8'd1);
    m_resp[0] = 8'h22; m_mesi[0] = 8'd7;
    cycle();
    chk("t2_resp2", 2, s_resp[2], 8'h22); chk("t2_mesi2", 2, s_mesi[2], 8'd3);
    cycle();

    // busy drop and back-to-back issue in the completion cycle
    s_rqst[1] = 8'h13;
    cycle();
    s_rqst[1] = 8'h12; m_resp[0] = 8'h13; m_mesi[0] = 8'd2; m_resp[2] = 8'h13;
    cycle();
    chk("t3_resp", 1, s_resp[1], 8'h13); chk("t3_mesi", 1, s_mesi[1], 8'd2);
    s_rqst[1] = 8'h14;
    cycle();
    chk("t3_single", 1, s_resp[1], 8'h00); chk("t3_b2b_fwd", 0, m_rqst[0], 8'h14);
    m_resp[0] = 8'h14; m_resp[2] = 8'h14;
    cycle();
    chk("t3_resp_b2b", 1, s_resp[1], 8'h14);
    cycle();
    chk("t3_nodrop", 0, m_rqst[0], 8'h00);

`ifdef COHUB_TIMEOUT_EN
    // silent targets: error completion after TMO edges, late answer ignored
    s_rqst[0] = 8'h2A;
    cycle();
    for (int i = 1; i < TMO; i++) cycle();
    chk("tmo_early", 0, s_resp[0], 8'h00);
    cycle();
    chk("tmo_resp", 0, s_resp[0], 8'h2A); chk("tmo_mesi", 0, s_mesi[0], 8'hFF);
    m_resp[1] = 8'h2A; m_mesi[1] = 8'd3;
    cycle();
    chk("tmo_idle", 0, s_resp[0], 8'h00);
    m_resp[2] = 8'h2A; m_mesi[2] = 8'd3;
    cycle();
    chk("tmo_late", 0, s_resp[0], 8'h00);
`endif

    // randomized traffic with agent responders
    auto_en = 1; spur_en = 1;
    for (int k = 0; k < PN; k++) seq[k] = 1;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < PN; k++) begin
        if ($urandom_range(3) == 0) begin
          s_rqst[k] = 8'(((k + 1) << 5) | seq[k]);
          s_trsc[k] = 8'($urandom);
          s_addr[k] = {$urandom, $urandom};
          seq[k] = seq[k] % 31 + 1;
        end
        if ($urandom_range(7) == 0) s_lock[k] = ~s_lock[k];
      end
      cycle();
    end
    s_lock = '0; spur_en = 0;
    repeat (30) cycle();

    // reset in the middle of a broadcast
    auto_en = 0;
    s_rqst[1] = 8'h15; s_rqst[2] = 8'h56; s_lock = 3'b010;
    cycle();
    rst_n = 1'b0;
    #1;
    chk("mrst_s_resp", 0, s_resp, 0); chk("mrst_m_rqst", 0, m_rqst, 0);
    chk("mrst_m_trsc", 0, m_trsc, 0); chk("mrst_m_lock", 0, m_lock, 0);
    chk("mrst_s_mesi", 0, s_mesi, 0); chk("mrst_m_addr", 0, m_addr[0] | m_addr[1] | m_addr[2], 0);
    model_reset(); pq.delete(); s_lock = '0;
    @(negedge clk); rst_n = 1'b1;
    m_resp[0] = 8'h15; m_resp[1] = 8'h56;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("post_rst_resp", i, s_resp, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
